// File: rtl/tdc_pkg.sv
// Shared widths, FSM state encoding and timestamp layout for the TDC capture block.
package tdc_pkg;

   localparam int COARSE_W_DEF = 24;
   localparam int FINE_W_DEF   = 6;
   localparam int TS_W_DEF     = 1 + COARSE_W_DEF + FINE_W_DEF;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_CAPTURE = 1'b1
   } tdc_state_e;

   typedef struct packed {
      logic                    pol;
      logic [COARSE_W_DEF-1:0] coarse;
      logic [FINE_W_DEF-1:0]   fine;
   } tdc_ts_t;

endpackage

// File: rtl/tdc_ts_fifo.sv
// Timestamp FIFO: registered pointers with a wrap bit, flag-based full/empty,
// head word presented combinationally so it holds steady until popped.
module tdc_ts_fifo
   import tdc_pkg::*;
#(
   parameter int W     = TS_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wptr_q, wptr_d;
   logic [AW:0]  rptr_q, rptr_d;
   logic         do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);

   assign wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
   assign rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/tdc_capture.sv
// Edge timestamper: synchronizes signal_in, strobes the delay line and queues {pol, coarse, fine}.
// Optional macro TDC_CAPTURE_BOTH_EDGES_EN also captures falling edges (pol=0).
module tdc_capture
   import tdc_pkg::*;
#(
   parameter int COARSE_W   = COARSE_W_DEF,
   parameter int FINE_W     = FINE_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       signal_in,
   input  logic                       arm,
   output logic                       sample,
   input  logic [FINE_W-1:0]          fine_count,
   output logic [COARSE_W+FINE_W:0]   ts_data,
   output logic                       ts_valid,
   input  logic                       ts_ready,
   output logic                       overflow,
   input  logic                       clear_ovf
);

   localparam int TS_W = COARSE_W + FINE_W + 1;

   logic                sync1_q, sync2_q, sync3_q;
   logic                edge_rise, edge_hit, edge_pol;
   tdc_state_e          state_q, state_d;
   logic [COARSE_W-1:0] coarse_q, cap_coarse_q;
   logic                cap_pol_q;
   logic                overflow_q, overflow_d;
   logic                push, pop, ovf_evt;
   logic                fifo_full, fifo_empty;
   logic [TS_W-1:0]     push_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= signal_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign edge_rise = sync2_q & ~sync3_q;
`ifdef TDC_CAPTURE_BOTH_EDGES_EN
   logic edge_fall;
   assign edge_fall = ~sync2_q & sync3_q;
   assign edge_hit  = edge_rise | edge_fall;
   assign edge_pol  = edge_rise;
`else
   assign edge_hit  = edge_rise;
   assign edge_pol  = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      sample  = 1'b0;
      push    = 1'b0;
      if (state_q == ST_IDLE) begin
         if (arm && edge_hit) begin
            sample  = 1'b1;
            state_d = ST_CAPTURE;
         end
      end else begin
         push    = 1'b1;
         state_d = ST_IDLE;
      end
   end

   assign ts_valid  = ~fifo_empty;
   assign pop       = ts_valid & ts_ready;
   // Lost event: edge arriving while busy, or a push refused by a full FIFO with no pop alongside.
   assign ovf_evt    = ((state_q == ST_CAPTURE) && edge_hit) || (push && fifo_full && !pop);
   assign overflow_d = ovf_evt ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
   assign overflow   = overflow_q;
   assign push_data  = {cap_pol_q, cap_coarse_q, fine_count};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         coarse_q     <= '0;
         cap_coarse_q <= '0;
         cap_pol_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         coarse_q   <= coarse_q + 1'b1;
         overflow_q <= overflow_d;
         if (sample) begin
            cap_coarse_q <= coarse_q;
            cap_pol_q    <= edge_pol;
         end
      end
   end

   tdc_ts_fifo #(
      .W     (TS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_data),
      .rdata_o (ts_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_tdc_capture.sv
// Directed bench for tdc_capture; a second narrow-coarse instance exercises counter wrap.
// Covers both builds of TDC_CAPTURE_BOTH_EDGES_EN.
module tb_tdc_capture;
   import tdc_pkg::*;

   localparam int CW  = 24;
   localparam int FW  = 6;
   localparam int TW  = CW + FW + 1;
   localparam int WCW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          signal_in = 1'b0;
   logic          arm = 1'b0;
   logic          ts_ready = 1'b0;
   logic          clear_ovf = 1'b0;
   logic [FW-1:0] fine_count = '0;
   logic          sample, ts_valid, overflow;
   logic [TW-1:0] ts_data;

   logic             signal_w = 1'b0;
   logic             ts_ready_w = 1'b0;
   logic             sample_w, ts_valid_w, overflow_w;
   logic [WCW+FW:0]  ts_data_w;

   int cyc;
   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   tdc_capture #(.COARSE_W(CW), .FINE_W(FW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .arm(arm), .sample(sample),
      .fine_count(fine_count), .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
      .overflow(overflow), .clear_ovf(clear_ovf)
   );

   tdc_capture #(.COARSE_W(WCW), .FINE_W(FW), .FIFO_DEPTH(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .signal_in(signal_w), .arm(arm), .sample(sample_w),
      .fine_count(fine_count), .ts_data(ts_data_w), .ts_valid(ts_valid_w), .ts_ready(ts_ready_w),
      .overflow(overflow_w), .clear_ovf(clear_ovf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic pol, input int coarse, input logic [FW-1:0] fine);
      logic [CW-1:0] c;
      c = CW'(coarse);
      return {33'd0, pol, c, fine};
   endfunction

   // Drive one level change; sample is due 2 cycles on, fine_count the cycle after, entry 1 later.
   task automatic edge_go(input logic lvl, input logic [FW-1:0] fv, input logic exp_samp,
                          input logic rdy_push, input logic chk_v, output int exp_c);
      @(negedge clk);
      signal_in  = lvl;
      exp_c      = cyc + 2;
      fine_count = ~fv;
      @(negedge clk);
      check("samp_pre", sample, 1'b0);
      @(negedge clk);
      check("samp_on", sample, exp_samp);
      @(negedge clk);
      check("samp_off", sample, 1'b0);
      if (chk_v) check("valid_early", ts_valid, 1'b0);
      fine_count = fv;
      ts_ready   = rdy_push;
      @(negedge clk);
      fine_count = ~fv;
      ts_ready   = 1'b0;
      if (chk_v) check("valid_lat", ts_valid, 1'b1);
   endtask

   task automatic lower();
      arm       = 1'b0;
      signal_in = 1'b0;
      repeat (4) @(negedge clk);
      arm = 1'b1;
   endtask

   task automatic rise(input logic [FW-1:0] fv, input logic rdy_push, output int exp_c);
      edge_go(1'b1, fv, 1'b1, rdy_push, 1'b0, exp_c);
      lower();
      @(negedge clk);
   endtask

   task automatic pop_chk(input string tag, input logic [63:0] exp);
      check({tag, "_v"}, ts_valid, 1'b1);
      check(tag, ts_data, exp);
      $display("pop %s data=0x%0h", tag, ts_data);
      ts_ready = 1'b1;
      @(negedge clk);
      ts_ready = 1'b0;
   endtask

   task automatic pop_w(input string tag, input logic [WCW:0] exp);
      check({tag, "_v"}, ts_valid_w, 1'b1);
      check(tag, ts_data_w[FW +: WCW+1], exp);
      $display("pop %s data=0x%0h", tag, ts_data_w);
      ts_ready_w = 1'b1;
      @(negedge clk);
      ts_ready_w = 1'b0;
   endtask

   task automatic clr_pulse();
      clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      int cs[6];

      repeat (3) @(negedge clk);
      check("rst_sample", sample, 1'b0);
      check("rst_valid", ts_valid, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      rst_n = 1'b1;
      arm   = 1'b1;

      // Single rising edge: coarse 100, fine 17.
      while (cyc != 97) @(negedge clk);
      edge_go(1'b1, 6'd17, 1'b1, 1'b0, 1'b1, c);
      check("single_ovf", overflow, 1'b0);
      pop_chk("single", mk(1'b1, 100, 6'd17));
      check("single_empty", ts_valid, 1'b0);
      lower();

      // Five edges into a depth-4 FIFO with no readout.
      for (int i = 0; i < 5; i++) begin
         rise(6'(10 + i), 1'b0, cs[i]);
         if (i == 3) check("ovf_at4", overflow, 1'b0);
      end
      check("ovf_drop", overflow, 1'b1);
      clr_pulse();
      check("ovf_clr", overflow, 1'b0);
      // Clear held through a refused push: the new overflow wins.
      clear_ovf = 1'b1;
      edge_go(1'b1, 6'd30, 1'b1, 1'b0, 1'b0, c);
      check("ovf_coincide", overflow, 1'b1);
      clear_ovf = 1'b0;
      lower();
      clr_pulse();
      check("ovf_clr2", overflow, 1'b0);
      for (int i = 0; i < 4; i++) pop_chk("keep", mk(1'b1, cs[i], 6'(10 + i)));
      check("keep_empty", ts_valid, 1'b0);

      // Full FIFO with ts_ready in the push cycle: pop and push together.
      for (int i = 0; i < 4; i++) rise(6'(20 + i), 1'b0, cs[i]);
      rise(6'd24, 1'b1, cs[4]);
      check("thru_ovf", overflow, 1'b0);
      for (int i = 1; i < 5; i++) pop_chk("thru", mk(1'b1, cs[i], 6'(20 + i)));
      check("thru_empty", ts_valid, 1'b0);

`ifdef TDC_CAPTURE_BOTH_EDGES_EN
      // One-cycle pulse: falling edge lands during CAPTURE.
      @(negedge clk);
      signal_in = 1'b1;
      c = cyc + 2;
      @(negedge clk);
      signal_in = 1'b0;
      @(negedge clk);
      check("p1_samp", sample, 1'b1);
      @(negedge clk);
      check("p1_busy", sample, 1'b0);
      fine_count = 6'd5;
      @(negedge clk);
      fine_count = 6'd0;
      check("p1_ovf", overflow, 1'b1);
      pop_chk("p1", mk(1'b1, c, 6'd5));
      check("p1_only", ts_valid, 1'b0);
      clr_pulse();
      check("p1_clr", overflow, 1'b0);
      // Four-cycle pulse: both edges captured.
      @(negedge clk);
      signal_in = 1'b1;
      c = cyc + 2;
      @(negedge clk);
      @(negedge clk);
      check("p4_rise", sample, 1'b1);
      @(negedge clk);
      fine_count = 6'd7;
      @(negedge clk);
      signal_in  = 1'b0;
      fine_count = 6'd0;
      @(negedge clk);
      @(negedge clk);
      check("p4_fall", sample, 1'b1);
      @(negedge clk);
      fine_count = 6'd8;
      @(negedge clk);
      fine_count = 6'd0;
      pop_chk("p4_r", mk(1'b1, c, 6'd7));
      pop_chk("p4_f", mk(1'b0, c + 4, 6'd8));
      check("p4_empty", ts_valid, 1'b0);
      check("p4_ovf", overflow, 1'b0);
`else
      // Falling edge with arm high must not qualify.
      arm       = 1'b0;
      signal_in = 1'b1;
      repeat (4) @(negedge clk);
      arm = 1'b1;
      edge_go(1'b0, 6'd9, 1'b0, 1'b0, 1'b0, c);
      repeat (2) @(negedge clk);
      check("fall_ignored", ts_valid, 1'b0);
      check("fall_ovf", overflow, 1'b0);
`endif
      lower();

      // Wrap on the 8-bit coarse instance: 0xFF then, five cycles later, 0x04.
      while ((cyc & 255) != 252) @(negedge clk);
      @(negedge clk);
      signal_w = 1'b1;
      repeat (2) @(negedge clk);
      signal_w = 1'b0;
      repeat (3) @(negedge clk);
      signal_w = 1'b1;
      repeat (6) @(negedge clk);
      pop_w("wrap_ff", {1'b1, 8'hFF});
`ifdef TDC_CAPTURE_BOTH_EDGES_EN
      pop_w("wrap_fall", {1'b0, 8'h01});
`endif
      pop_w("wrap_04", {1'b1, 8'h04});
      check("wrap_empty", ts_valid_w, 1'b0);
      arm      = 1'b0;
      signal_w = 1'b0;
      repeat (4) @(negedge clk);
      arm = 1'b1;

      // Reset during CAPTURE with a full FIFO and overflow set.
      for (int i = 0; i < 5; i++) rise(6'(40 + i), 1'b0, cs[i]);
      check("pre_rst_ovf", overflow, 1'b1);
      @(negedge clk);
      signal_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_samp", sample, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_sample", sample, 1'b0);
      check("arst_valid", ts_valid, 1'b0);
      check("arst_ovf", overflow, 1'b0);
      signal_in = 1'b0;
      arm       = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      arm   = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_no_push", ts_valid, 1'b0);
      check("rst_ovf_hold", overflow, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
